multicycle_ctrl: RTL and testbench

- Main control FSM for the multicycle RV32 datapath.
- Drives the 32-bit ALU's 2-bit operation select (0 ADD, 1 AND, 2 PASS_B) plus all datapath mux selects and write enables, one instruction step per state.
- Sits directly upstream of the ALU. Consumes the instruction register's opcode/funct fields and a memory ready handshake.
- Supported instructions: lw, sw, add, and, addi, andi, lui, jal. Anything else traps.

---
 rtl/ctrl_pkg.sv | 51 +++++
 rtl/alu_decoder.sv | 28 ++
 rtl/multicycle_ctrl.sv | 164 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32 control unit:
// FSM states, ALU operation codes, opcodes and datapath select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_LUI,
    S_JAL,
    S_ALUWB,
    S_TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_AND   = 2'd1;
  localparam logic [1:0] ALU_PASSB = 2'd2;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_OLDPC = 2'd1;
  localparam logic [1:0] SRCA_RS1   = 2'd2;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from the current control state and funct3.
// Flags funct3 values the execute states cannot handle.
module alu_decoder
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [2:0] funct3,
  output logic [1:0] alu_control,
  output logic       illegal_funct3
);

  always_comb begin
    alu_control    = ALU_ADD;
    illegal_funct3 = 1'b0;
    case (state)
      S_EXECR, S_EXECI: begin
        case (funct3)
          F3_ADD:  alu_control = ALU_ADD;
          F3_AND:  alu_control = ALU_AND;
          default: illegal_funct3 = 1'b1;
        endcase
      end
      S_LUI:   alu_control = ALU_PASSB;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32 datapath: one instruction step per
// state, memory wait states with an optional stall timeout, sticky trap.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       mem_req,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_t            state_reg, state_next;
  logic [TO_W-1:0]   cnt_reg, cnt_next;
  logic              illegal_funct3;
  logic              is_wait;
  logic              timeout;

  alu_decoder u_alu_dec (
    .state          (state_reg),
    .funct3         (funct3),
    .alu_control    (alu_control),
    .illegal_funct3 (illegal_funct3)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    is_wait    = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                 (state_reg == S_MEMWRITE);
    cnt_next   = '0;
    timeout    = 1'b0;
    state_next = state_reg;
    // The counter only advances while a wait state is stalled; any other
    // cycle either changes state or sits in TRAP, so it returns to zero.
    if (is_wait && !mem_ready) begin
      cnt_next = cnt_reg + TO_W'(1);
      timeout  = (MEM_TIMEOUT != 0) && (cnt_next == TO_W'(MEM_TIMEOUT));
    end
    case (state_reg)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:   state_next = ((funct7 == 7'd0) &&
                                ((funct3 == F3_ADD) || (funct3 == F3_AND)))
                               ? S_EXECR : S_TRAP;
          OP_I:   state_next = S_EXECI;
          OP_LUI: state_next = S_LUI;
          OP_JAL: state_next = S_JAL;
          default: state_next = S_TRAP;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR:    state_next = S_ALUWB;
      S_EXECI:    state_next = illegal_funct3 ? S_TRAP : S_ALUWB;
      S_LUI:      state_next = S_ALUWB;
      S_JAL:      state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      default:    state_next = S_TRAP;
    endcase
    if (timeout) begin
      state_next = S_TRAP;
      cnt_next   = '0;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    mem_req       = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    illegal_instr = (state_reg == S_TRAP);
    case (state_reg)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR:    alu_src_a = SRCA_RS1;
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_LUI:      alu_src_b = SRCB_IMM;
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = IMM_S;
      OP_JAL:  imm_src = IMM_J;
      OP_LUI:  imm_src = IMM_U;
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table of instruction step traces
// plus hand sequences for stalls, mid-write reset, traps and timeout.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic [6:0] funct7 = 7'd0;
  logic       mem_ready = 1'b0;

  logic       pc_write, adr_src, mem_write, mem_req, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_control;
  logic [2:0] imm_src;

  logic       pc_write_z, adr_src_z, mem_write_z, mem_req_z, ir_write_z, reg_write_z, illegal_instr_z;
  logic [1:0] result_src_z, alu_src_a_z, alu_src_b_z, alu_control_z;
  logic [2:0] imm_src_z;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
    .mem_write(mem_write), .mem_req(mem_req), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_write(reg_write),
    .illegal_instr(illegal_instr)
  );

  multicycle_ctrl #(.MEM_TIMEOUT(0), .TO_W(5)) u_dut_nto (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .pc_write(pc_write_z), .adr_src(adr_src_z),
    .mem_write(mem_write_z), .mem_req(mem_req_z), .ir_write(ir_write_z),
    .result_src(result_src_z), .alu_src_a(alu_src_a_z), .alu_src_b(alu_src_b_z),
    .alu_control(alu_control_z), .imm_src(imm_src_z), .reg_write(reg_write_z),
    .illegal_instr(illegal_instr_z)
  );

  // Output bundle: pc_write,adr_src,mem_write,mem_req,ir_write,result_src,
  // alu_src_a,alu_src_b,alu_control,imm_src,reg_write,illegal_instr
  logic [17:0] got, got_z;
  assign got   = {pc_write, adr_src, mem_write, mem_req, ir_write, result_src,
                  alu_src_a, alu_src_b, alu_control, imm_src, reg_write, illegal_instr};
  assign got_z = {pc_write_z, adr_src_z, mem_write_z, mem_req_z, ir_write_z, result_src_z,
                  alu_src_a_z, alu_src_b_z, alu_control_z, imm_src_z, reg_write_z, illegal_instr_z};

  typedef enum logic [3:0] {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_LUI, T_JAL, T_ALUWB, T_TRAP
  } step_t;

  typedef struct {
    logic [6:0]    op;
    logic [2:0]    f3;
    logic [6:0]    f7;
    int            n;
    step_t [0:4]   steps;
  } vec_t;

  vec_t        vecs[$];
  logic [17:0] sb[$];
  int          checks = 0;
  int          failures = 0;
  int          ir_cnt, pc_cnt, rw_cnt;

  function automatic logic [17:0] exp_out(step_t s, logic [6:0] op, logic [2:0] f3, logic rdy);
    logic       pcw = 1'b0, adr = 1'b0, mw = 1'b0, mr = 1'b0, irw = 1'b0, rw = 1'b0, ill = 1'b0;
    logic [1:0] res = 2'd0, sa = 2'd0, sbx = 2'd0, alu = 2'd0;
    logic [2:0] imm;
    imm = (op == 7'b0100011) ? 3'd1 : (op == 7'b1101111) ? 3'd3 :
          (op == 7'b0110111) ? 3'd4 : 3'd0;
    case (s)
      T_FETCH:    begin mr = 1'b1; sbx = 2'd2; res = 2'd2; irw = rdy; pcw = rdy; end
      T_DECODE:   begin sa = 2'd1; sbx = 2'd1; end
      T_MEMADR:   begin sa = 2'd2; sbx = 2'd1; end
      T_MEMREAD:  begin mr = 1'b1; adr = 1'b1; end
      T_MEMWB:    begin res = 2'd1; rw = 1'b1; end
      T_MEMWRITE: begin mr = 1'b1; adr = 1'b1; mw = 1'b1; end
      T_EXECR:    begin sa = 2'd2; alu = (f3 == 3'b111) ? 2'd1 : 2'd0; end
      T_EXECI:    begin sa = 2'd2; sbx = 2'd1; alu = (f3 == 3'b111) ? 2'd1 : 2'd0; end
      T_LUI:      begin sbx = 2'd1; alu = 2'd2; end
      T_JAL:      begin sa = 2'd1; sbx = 2'd2; pcw = 1'b1; end
      T_ALUWB:    begin rw = 1'b1; end
      default:    begin ill = 1'b1; end
    endcase
    return {pcw, adr, mw, mr, irw, res, sa, sbx, alu, imm, rw, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got_v, exp_v);
    end
  endtask

  // One cycle: drive inputs, push expectation, compare at the falling edge.
  task automatic step(input step_t s, input logic rdy);
    logic [17:0] e;
    mem_ready = rdy;
    sb.push_back(exp_out(s, opcode, funct3, rdy));
    @(negedge clk);
    e = sb.pop_front();
    check($sformatf("step_%s_op%b", s.name(), opcode), {14'd0, got}, {14'd0, e});
    ir_cnt += int'(ir_write);
    pc_cnt += int'(pc_write);
    rw_cnt += int'(reg_write);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", {14'd0, got}, {14'd0, exp_out(T_FETCH, opcode, funct3, 1'b0)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input int n, input step_t s0, input step_t s1, input step_t s2,
                         input step_t s3, input step_t s4);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.n = n;
    v.steps[0] = s0; v.steps[1] = s1; v.steps[2] = s2; v.steps[3] = s3; v.steps[4] = s4;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec(7'b0110011, 3'b000, 7'd0, 4, T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH);
    add_vec(7'b0110011, 3'b111, 7'd0, 4, T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH);
    add_vec(7'b0010011, 3'b000, 7'd0, 4, T_FETCH, T_DECODE, T_EXECI, T_ALUWB, T_FETCH);
    add_vec(7'b0010011, 3'b111, 7'd0, 4, T_FETCH, T_DECODE, T_EXECI, T_ALUWB, T_FETCH);
    add_vec(7'b0110111, 3'b000, 7'd0, 4, T_FETCH, T_DECODE, T_LUI, T_ALUWB, T_FETCH);
    add_vec(7'b1101111, 3'b000, 7'd0, 4, T_FETCH, T_DECODE, T_JAL, T_ALUWB, T_FETCH);
    add_vec(7'b0000011, 3'b010, 7'd0, 5, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB);
    add_vec(7'b0100011, 3'b010, 7'd0, 4, T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE, T_FETCH);
    add_vec(7'b1100011, 3'b000, 7'd0, 3, T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP);
    add_vec(7'b0110011, 3'b000, 7'b0100000, 3, T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP);
    add_vec(7'b0110011, 3'b110, 7'd0, 3, T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP);
    add_vec(7'b0010011, 3'b001, 7'd0, 4, T_FETCH, T_DECODE, T_EXECI, T_TRAP, T_TRAP);

    do_reset();

    foreach (vecs[k]) begin
      opcode = vecs[k].op;
      funct3 = vecs[k].f3;
      funct7 = vecs[k].f7;
      for (int i = 0; i < vecs[k].n; i++) step(vecs[k].steps[i], 1'b1);
      $display("vec %0d op=%b f3=%b f7=%b cycles=%0d", k, vecs[k].op, vecs[k].f3,
               vecs[k].f7, vecs[k].n);
      if (vecs[k].steps[vecs[k].n-1] == T_TRAP) begin
        step(T_TRAP, 1'b1);
        step(T_TRAP, 1'b0);
        do_reset();
      end
    end

    // lw with 3 stalled fetch cycles and 2 stalled read cycles: 10 cycles.
    opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'd0;
    ir_cnt = 0; pc_cnt = 0; rw_cnt = 0;
    repeat (3) step(T_FETCH, 1'b0);
    step(T_FETCH, 1'b1);
    step(T_DECODE, 1'b1);
    step(T_MEMADR, 1'b1);
    repeat (2) step(T_MEMREAD, 1'b0);
    step(T_MEMREAD, 1'b1);
    step(T_MEMWB, 1'b1);
    check("lw_ir_write_pulses", ir_cnt, 1);
    check("lw_pc_write_pulses", pc_cnt, 1);
    check("lw_reg_write_pulses", rw_cnt, 1);
    $display("seq lw_stalled cycles=10");

    // sw with a stalled write: mem_write held until mem_ready.
    opcode = 7'b0100011;
    step(T_FETCH, 1'b1);
    step(T_DECODE, 1'b1);
    step(T_MEMADR, 1'b1);
    repeat (3) step(T_MEMWRITE, 1'b0);
    step(T_MEMWRITE, 1'b1);
    $display("seq sw_stalled");

    // Reset asserted while a write is pending.
    step(T_FETCH, 1'b1);
    step(T_DECODE, 1'b1);
    step(T_MEMADR, 1'b1);
    step(T_MEMWRITE, 1'b0);
    #2;
    check("pre_reset_mem_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_mem_write", {31'd0, mem_write}, 32'd0);
    check("async_reset_outputs", {14'd0, got}, {14'd0, exp_out(T_FETCH, opcode, funct3, 1'b0)});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(T_FETCH, 1'b0);
    $display("seq reset_mid_write");

    // Fetch stuck: timeout instance traps after 16 cycles, the other never.
    opcode = 7'b0110011; funct3 = 3'b000;
    do_reset();
    repeat (16) step(T_FETCH, 1'b0);
    step(T_TRAP, 1'b0);
    step(T_TRAP, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("no_timeout_fetch", {14'd0, got_z}, {14'd0, exp_out(T_FETCH, opcode, funct3, 1'b0)});
    check("timeout_sticky", {31'd0, illegal_instr}, 32'd1);
    $display("seq fetch_timeout");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
